// File: rtl/mem_dma_pkg.sv
// mem_dma_pkg: shared types for the mem_dma block-transfer initiator.
//   state_t   - transfer FSM states
//   MODE_*    - values of the mode input (copy / fill)
package mem_dma_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // waiting for start
        RD   = 2'd1,   // copy: issue read of src_ptr
        WR   = 2'd2,   // issue write of dst_ptr
        FIN  = 2'd3    // one-cycle completion pulse
    } state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_dma.sv
// mem_dma: block copy / block fill initiator for a single-port synchronous
// RAM with one-cycle registered read data.
//
// Ports
//   clk, reset           rising-edge clock, synchronous active-low reset
//   start                one-cycle request, only honoured in IDLE
//   mode                 0 = copy (src -> dst), 1 = fill (fill_val -> dst)
//   src, dst, len        start addresses and word count (len 0..2^ADDR_SIZE)
//   fill_val             constant word for fill mode
//   abort                level; ends the transfer early
//   busy                 high while reading/writing (RD/WR states)
//   done                 one-cycle pulse on normal completion
//   aborted              sticky abort flag, cleared by the next accepted start
//   count                words written in the current/last transfer
//   mem_cs/mem_wen/mem_addr/mem_wdata/mem_rdata   RAM port
//
// Copy runs RD,WR per word (2 cycles/word); fill runs WR back to back.
// In copy mode the read data returned during WR is forwarded straight to
// mem_wdata, so that is the only combinational input-to-output path.
module mem_dma
    import mem_dma_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ADDR_SIZE = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode,
    input  logic [ADDR_SIZE-1:0] src,
    input  logic [ADDR_SIZE-1:0] dst,
    input  logic [ADDR_SIZE:0]   len,
    input  logic [WIDTH-1:0]     fill_val,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [ADDR_SIZE:0]   count,
    output logic                 mem_cs,
    output logic                 mem_wen,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WIDTH-1:0]     mem_wdata,
    input  logic [WIDTH-1:0]     mem_rdata
);

    localparam logic [ADDR_SIZE-1:0] ONE_A = 1;
    localparam logic [ADDR_SIZE:0]   ONE_C = 1;

    state_t                 state, state_nxt;

    // Parameters captured with an accepted start
    logic                   mode_q;
    logic [ADDR_SIZE-1:0]   src_ptr;
    logic [ADDR_SIZE-1:0]   dst_ptr;
    logic [ADDR_SIZE:0]     len_q;
    logic [WIDTH-1:0]       fill_q;

    logic [ADDR_SIZE:0]     cnt_q;
    logic [ADDR_SIZE:0]     cnt_inc;
    logic                   aborted_q;
    logic                   last_word;

    // count never exceeds len-1 while in WR, so the increment cannot
    // overflow the ADDR_SIZE+1 bit counter even for len = 2^ADDR_SIZE.
    assign cnt_inc   = cnt_q + ONE_C;
    assign last_word = (cnt_inc == len_q);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0)               state_nxt = FIN;
                    else if (mode == MODE_FILL)  state_nxt = WR;
                    else                         state_nxt = RD;
                end
            end
            RD: begin
                // abort here cancels the word before its write is issued
                state_nxt = abort ? IDLE : WR;
            end
            WR: begin
                // the write presented this cycle always lands; abort only
                // stops anything after it, and suppresses done
                if (abort)                       state_nxt = IDLE;
                else if (last_word)              state_nxt = FIN;
                else if (mode_q == MODE_COPY)    state_nxt = RD;
                else                             state_nxt = WR;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded from state (plus copy-mode read-data forwarding)
    // ------------------------------------------------------------------
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_cs    = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            RD: begin
                busy     = 1'b1;
                mem_cs   = 1'b1;
                mem_addr = src_ptr;
            end
            WR: begin
                busy      = 1'b1;
                mem_cs    = 1'b1;
                mem_wen   = 1'b1;
                mem_addr  = dst_ptr;
                mem_wdata = (mode_q == MODE_FILL) ? fill_q : mem_rdata;
            end
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: parameter capture, pointers, word counter, abort flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q    <= MODE_COPY;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            len_q     <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q    <= mode;
                        src_ptr   <= src;
                        dst_ptr   <= dst;
                        len_q     <= len;
                        fill_q    <= fill_val;
                        cnt_q     <= '0;
                        aborted_q <= 1'b0;
                    end
                end
                RD: begin
                    if (abort) aborted_q <= 1'b1;
                end
                WR: begin
                    // pointers wrap naturally at 2^ADDR_SIZE
                    cnt_q   <= cnt_inc;
                    dst_ptr <= dst_ptr + ONE_A;
                    if (mode_q == MODE_COPY) src_ptr <= src_ptr + ONE_A;
                    if (abort) aborted_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign count   = cnt_q;
    assign aborted = aborted_q;

endmodule
